// File: rtl/sr_univ_if.sv
// Bus bundle for the universal shift register: control/data in, register view and status out.
// state_dbg exposes the controller state so checkers can bind without reaching into the block.
interface sr_univ_if #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
);
    logic [1:0]       mode;
    logic             load;
    logic [WIDTH-1:0] pi;
    logic             si;
    logic             start;
    logic [CNT_W-1:0] len;
    logic [WIDTH-1:0] po;
    logic             so;
    logic             busy;
    logic             done;
    logic [1:0]       state_dbg;

    modport master (
        output mode, load, pi, si, start, len,
        input  po, so, busy, done, state_dbg
    );

    modport slave (
        input  mode, load, pi, si, start, len,
        output po, so, busy, done, state_dbg
    );
endinterface

// File: rtl/sr_univ.sv
// Parametrised universal shift register with parallel load, four shift/rotate modes
// and a counted burst controller reporting busy/done.
module sr_univ #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
) (
    input  logic     clk,
    input  logic     rst,
    sr_univ_if.slave bus
);

    // Handshake: start (with mode/len) is accepted only on an IDLE edge with load low.
    // busy is high for the len cycles in which shifts happen; done pulses for one cycle
    // afterwards; the block returns to IDLE one cycle after done and never raises both.
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] sr_q, sr_d, sr_op;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       mode_q, mode_d;
    logic             busy_q, done_q;

    // One step of the latched operation; si only matters in the shift modes.
    always_comb begin
        sr_op = sr_q;
        case (mode_q)
            2'b00:   sr_op = {sr_q[WIDTH-2:0], bus.si};
            2'b01:   sr_op = {bus.si, sr_q[WIDTH-1:1]};
            2'b10:   sr_op = {sr_q[WIDTH-2:0], sr_q[WIDTH-1]};
            default: sr_op = {sr_q[0], sr_q[WIDTH-1:1]};
        endcase
    end

    always_comb begin
        state_d = state_q;
        sr_d    = sr_q;
        cnt_d   = cnt_q;
        mode_d  = mode_q;
        case (state_q)
            S_IDLE: begin
                if (bus.load) begin
                    sr_d = bus.pi;
                end else if (bus.start) begin
                    mode_d = bus.mode;
                    if (bus.len != '0) begin
                        cnt_d   = bus.len;
                        state_d = S_SHIFT;
                    end else begin
                        state_d = S_DONE;
                    end
                end
            end
            S_SHIFT: begin
                sr_d  = sr_op;
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            sr_q    <= '0;
            cnt_q   <= '0;
            mode_q  <= 2'b00;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sr_q    <= sr_d;
            cnt_q   <= cnt_d;
            mode_q  <= mode_d;
            busy_q  <= (state_d == S_SHIFT);
            done_q  <= (state_d == S_DONE);
        end
    end

    // Serial output tracks the end the latched mode shifts out of.
    assign bus.po        = sr_q;
    assign bus.so        = mode_q[0] ? sr_q[0] : sr_q[WIDTH-1];
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.state_dbg = state_q;

endmodule

// File: tb/tb_sr_univ.sv
// Bench for sr_univ: directed scenarios plus randomized traffic, checked every cycle
// against a timeline-based model of the register and burst windows.
module tb_sr_univ;
    localparam int WIDTH = 8;
    localparam int CNT_W = 4;
    localparam int VW    = WIDTH + 3;

    logic clk;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    sr_univ_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) bus ();

    sr_univ #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // ---------------- clock / reset ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- check helper ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [VW-1:0]    exp_q[$];
    logic [WIDTH-1:0] m_sr;
    logic [1:0]       m_mode;
    int               m_e, m_k, m_l;
    bit               m_active;

    function automatic logic [WIDTH-1:0] apply_op(input logic [WIDTH-1:0] v,
                                                   input logic [1:0] m, input logic s);
        logic [WIDTH-1:0] r;
        case (m)
            2'd0:    r = (v << 1) | WIDTH'(s);
            2'd1:    r = (v >> 1) | (WIDTH'(s) << (WIDTH - 1));
            2'd2:    r = (v << 1) | (v >> (WIDTH - 1));
            default: r = (v >> 1) | (v << (WIDTH - 1));
        endcase
        return r;
    endfunction

    // Burst accepted at edge k with length L: shifts on edges k+1..k+L, busy after
    // edges k..k+L-1, done after edge k+L, new requests honoured from edge k+L+2.
    initial begin
        bit idle, e_busy, e_done;
        logic e_so;
        forever begin
            @(posedge clk or negedge rst);
            if (!rst) begin
                m_sr = '0; m_mode = 2'b00; m_e = 0; m_k = 0; m_l = 0; m_active = 0;
                exp_q.delete();
            end else begin
                m_e++;
                idle = !m_active || (m_e >= m_k + m_l + 2);
                if (m_active && m_e >= m_k + 1 && m_e <= m_k + m_l) begin
                    m_sr = apply_op(m_sr, m_mode, bus.si);
                end else if (idle) begin
                    if (bus.load) begin
                        m_sr = bus.pi;
                    end else if (bus.start) begin
                        m_k = m_e; m_l = int'(bus.len); m_mode = bus.mode; m_active = 1;
                    end
                end
                e_busy = m_active && m_e >= m_k && m_e < m_k + m_l;
                e_done = m_active && m_e == m_k + m_l;
                e_so   = m_mode[0] ? m_sr[0] : m_sr[WIDTH-1];
                exp_q.push_back({m_sr, e_so, e_busy, e_done});
            end
        end
    end

    // ---------------- scoreboard compare ----------------
    initial begin
        logic [VW-1:0] e;
        forever begin
            @(negedge clk);
            if (!rst) begin
                chk("outputs_in_reset", {bus.po, bus.so, bus.busy, bus.done}, '0);
            end else if (exp_q.size() == 0) begin
                chk("scoreboard_has_entry", 0, 1);
            end else begin
                e = exp_q.pop_front();
                chk("outputs_vs_model", {bus.po, bus.so, bus.busy, bus.done}, e);
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic cyc(input int n);
        repeat (n) begin
            @(negedge clk);
            bus.load = 1'b0; bus.start = 1'b0; bus.si = 1'($urandom);
        end
    endtask

    task automatic do_load(input logic [WIDTH-1:0] v);
        @(negedge clk);
        bus.load = 1'b1; bus.start = 1'b0; bus.pi = v;
        @(negedge clk);
        bus.load = 1'b0;
        chk("load_po", bus.po, v);
    endtask

    task automatic burst(input logic [1:0] m, input int l, input logic [15:0] sib,
                         input bit disturb, input bit chk_so, input logic [15:0] so_exp,
                         input bit chk_po, input logic [WIDTH-1:0] po_exp);
        @(negedge clk);
        bus.load = 1'b0; bus.start = 1'b1; bus.mode = m; bus.len = CNT_W'(l);
        bus.si = 1'($urandom);
        for (int i = 0; i < l; i++) begin
            @(negedge clk);
            if (chk_so) chk("so_before_shift", bus.so, so_exp[i]);
            bus.start = 1'b0; bus.si = sib[i];
            if (disturb) begin
                bus.load  = 1'($urandom);
                bus.pi    = WIDTH'($urandom);
                bus.start = 1'($urandom);
                bus.mode  = 2'($urandom);
                bus.len   = CNT_W'($urandom);
            end
        end
        @(negedge clk);
        chk("done_pulse", bus.done, 1);
        chk("busy_low_at_done", bus.busy, 0);
        if (chk_po) chk("burst_po", bus.po, po_exp);
        bus.load = 1'b0;
        bus.start = disturb;
        bus.len = CNT_W'($urandom_range(1, 15));
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst = 1'b0;
        bus.mode = 2'b00; bus.load = 1'b0; bus.pi = '0; bus.si = 1'b0;
        bus.start = 1'b0; bus.len = '0;
        #1;
        chk("reset_state_dbg", bus.state_dbg, 0);
        repeat (2) @(negedge clk);
        #1 rst = 1'b1;

        // asynchronous reset during the third shift of a burst
        do_load(8'hA5);
        @(negedge clk);
        bus.start = 1'b1; bus.mode = 2'b00; bus.len = 4'd5; bus.si = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        chk("busy_in_burst", bus.busy, 1);
        repeat (2) @(negedge clk);
        @(posedge clk);
        #2 rst = 1'b0;
        #1;
        chk("async_po", bus.po, 0);
        chk("async_so", bus.so, 0);
        chk("async_busy", bus.busy, 0);
        chk("async_done", bus.done, 0);
        chk("async_state", bus.state_dbg, 0);
        repeat (2) @(negedge clk);
        #1 rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("idle_po_after_reset", bus.po, 0);

        // shift up / shift down
        do_load(8'h81);
        burst(2'b00, 3, 16'h0005, 0, 1, 16'h0001, 1, 8'h0D);
        do_load(8'h01);
        burst(2'b01, 2, 16'h0003, 0, 1, 16'h0001, 1, 8'hC0);

        // rotate wraps, si random
        do_load(8'h3C);
        burst(2'b10, 8, 16'($urandom), 0, 0, 16'h0, 1, 8'h3C);
        burst(2'b11, 12, 16'($urandom), 0, 0, 16'h0, 1, 8'hC3);

        // load wins over start; zero-length burst
        @(negedge clk);
        bus.load = 1'b1; bus.start = 1'b1; bus.pi = 8'h55; bus.len = 4'd3; bus.mode = 2'b10;
        @(negedge clk);
        bus.load = 1'b0; bus.start = 1'b0;
        chk("priority_po", bus.po, 8'h55);
        chk("priority_busy", bus.busy, 0);
        @(negedge clk);
        chk("priority_still_idle", bus.busy, 0);
        burst(2'b01, 0, 16'h0, 0, 0, 16'h0, 1, 8'h55);

        // requests during SHIFT and DONE are ignored
        do_load(8'h00);
        burst(2'b00, 4, 16'h000F, 1, 0, 16'h0, 1, 8'h0F);
        burst(2'b00, 2, 16'h0000, 0, 0, 16'h0, 1, 8'h3C);

        // randomized traffic
        repeat (250) begin
            case ($urandom_range(0, 9))
                0, 1, 2: do_load(WIDTH'($urandom));
                9:       cyc($urandom_range(1, 3));
                default: burst(2'($urandom), $urandom_range(0, 15), 16'($urandom),
                               ($urandom_range(0, 3) == 0), 0, 16'h0, 0, '0);
            endcase
        end
        cyc(3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/sr_univ.md
# sr_univ

Parametrised universal shift register: the next generation of the team's fixed 5-bit serial shift register. Adds configurable width, parallel load, four shift/rotate modes and a counted burst-shift controller with busy/done handshake. Used as a serialiser, deserialiser or barrel-style rotator behind a simple controller. Synchronous to one clock.

## Interface

Parameters:
- WIDTH, 8, register width in bits (>= 2)
- CNT_W, 4, width of the burst length field; maximum burst = 2^CNT_W - 1 shifts

Ports:
- clk  input  1  clock; all state changes on rising edge
- rst  input  1  reset, asynchronous, active-low
- mode  input  2  operation mode, sampled with start: 00 shift up, 01 shift down, 10 rotate up, 11 rotate down
- load  input  1  parallel load strobe, honoured in IDLE only
- pi  input  WIDTH  parallel load data
- si  input  1  serial input, sampled on every shift edge
- start  input  1  burst request, honoured in IDLE only
- len  input  CNT_W  number of shifts in the burst, sampled with start
- po  output  WIDTH  parallel output, the register contents
- so  output  1  serial output
- busy  output  1  high while a burst is shifting
- done  output  1  one-cycle pulse when a burst completes

## Operation

- Register SR[WIDTH-1:0]; po = SR.
- Shift up: SR <= {SR[WIDTH-2:0], si}. Shift down: SR <= {si, SR[WIDTH-1:1]}.
- Rotate up: SR <= {SR[WIDTH-2:0], SR[WIDTH-1]}. Rotate down: SR <= {SR[0], SR[WIDTH-1:1]}. si is ignored in rotate modes.
- Latched mode register mode_q (reset 00) is captured at an accepted start. so = SR[WIDTH-1] when mode_q[0]=0 (up modes); so = SR[0] when mode_q[0]=1 (down modes). so is combinational from registers only.
- State machine: IDLE, SHIFT, DONE.
  - IDLE: load=1 -> SR <= pi, stay IDLE; start is ignored in that cycle (load has priority). load=0, start=1, len!=0 -> capture mode_q, cnt <= len, go to SHIFT. load=0, start=1, len=0 -> capture mode_q, go directly to DONE, SR unchanged.
  - SHIFT: each edge performs one operation per mode_q and decrements cnt; the edge where cnt=1 performs the last operation and moves to DONE. load, start, mode and len are ignored.
  - DONE: one cycle, then IDLE. load and start are ignored.
- SR is held in IDLE and DONE unless a load occurs.
- len may exceed WIDTH: shift modes fully flush to si values; rotate modes wrap modulo WIDTH.

## Timing

- Reset (asserted asynchronously, at any time including mid-burst): SR=0, po=0, so=0, state=IDLE, cnt=0, mode_q=00, busy=0, done=0. Operation resumes on the first rising edge after deassertion.
- Load: po = pi after the edge sampling load=1. Latency is 1 cycle.
- Burst: start is accepted at edge k. busy=1 from after edge k until after edge k+len. Shifts occur at edges k+1 .. k+len, and si is sampled at each of those edges. done=1 for exactly the cycle between edges k+len and k+len+1. The next start can be accepted at edge k+len+2.
- len=0: done=1 for the cycle after edge k; busy stays 0.
- busy and done are registered and never high together.
- so reflects the new mode_q starting from the cycle after the start edge.

## Test plan

- Reset mid-burst: WIDTH=8, load 0xA5, start len=5; assert rst during the 3rd shift -> po=0, so=0, busy=0, done=0 immediately. After release, IDLE holds with po=0.
- Shift up: load 0x81, then start mode=00 len=3 with si=1,0,1 -> po=0x0D. busy is high for 3 cycles, then done pulses once. so during the burst shows SR[7] = 1,0,0 at the 3 shift edges.
- Shift down: load 0x01, then start mode=01 len=2 with si=1,1 -> po=0xC0. so (SR[0]) is 1 before the first shift.
- Rotate full wrap: load 0x3C, then start mode=10 len=8 -> po=0x3C. Next, start mode=11 len=12 -> po=0xC3. si is toggled randomly and has no effect.
- Zero-length and priority: in IDLE, load=1 and start=1 together with pi=0x55 -> po=0x55 and no busy. Then start len=0 -> done pulses one cycle later, busy stays 0, po=0x55.
- Ignored requests: during SHIFT, pulse load (pi=0xFF) and start -> both are ignored and the burst finishes with len shifts. start asserted during DONE -> ignored; start on the following IDLE cycle -> accepted.
